pwm_die_multi: RTL and testbench

Multi-channel complementary PWM generator with programmable dead time, per-channel phase offset and burst count. It is the parametrised successor of the single-pair dead-time generator. It sits between the control/enable logic and the ODDR2 output stage, all on `io_clk`. Each channel drives one a/b pair; the a and b outputs of a channel are never high at the same time.

---
 rtl/pwm_die_multi.sv | 191 +++++++++++++++++++
 tb/tb_pwm_die_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_die_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_die_multi                                                   |
// | Purpose  : Multi-channel complementary PWM with dead time, per-channel     |
// |            phase offset and burst count. Each channel drives an a/b pair   |
// |            that is never high at the same time.                            |
// | Option   : PWM_SOFT_STOP_EN - a stop request lets channel 0 finish its     |
// |            current period (STOP state) instead of stopping immediately.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pwm_die_multi #(
   parameter int CH_NUM = 2,
   parameter int CNT_W  = 32
) (
   input  logic              io_clk,
   input  logic              io_rst,
   input  logic              io_en,
   input  logic              pwm_dis,
   input  logic [CNT_W-1:0]  pulse_period,
   input  logic [CNT_W-1:0]  die_period,
   input  logic [CNT_W-1:0]  phase_step,
   input  logic [15:0]       burst_num,
   input  logic              io_defaultLevel,
   output logic [CH_NUM-1:0] io_pulseOut_a,
   output logic [CH_NUM-1:0] io_pulseOut_b,
   output logic              pulse_valid,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   // counters span a full period of 2P, hence one extra bit
   localparam int CW = CNT_W + 1;
   // room for (CH_NUM-1)*S with CH_NUM up to 8
   localparam int MW = CNT_W + 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1
`ifdef PWM_SOFT_STOP_EN
      , ST_STOP = 2'd2
`endif
   } state_t;

   state_t            state_q, state_d;
   logic              start_q, start_d;
   logic [CNT_W-1:0]  p_q, d_q, s_q;
   logic [15:0]       n_q;
   logic [15:0]       burst_q, burst_d;
   logic [CW-1:0]     c_q [CH_NUM];
   logic [CW-1:0]     c_d [CH_NUM];
   logic [CH_NUM-1:0] a_q, a_d, b_q, b_d;
   logic              pv_q, pv_d, done_q, done_d, err_q, err_d, busy_q, busy_d;

   logic [CW-1:0]     p_ext, d_ext, pd_sum, two_p, last_cnt;
   logic [CW-1:0]     off [CH_NUM];
   logic [MW-1:0]     span;
   logic              cfg_ok, wrap0, end_run;

   // derived timing thresholds and start-time configuration check
   always_comb begin
      p_ext    = {1'b0, p_q};
      d_ext    = {1'b0, d_q};
      pd_sum   = p_ext + d_ext;
      two_p    = {p_q, 1'b0};
      last_cnt = two_p - CW'(1);
      span     = MW'(CH_NUM - 1) * {4'b0000, s_q};
      cfg_ok   = (p_q != '0) && (d_q < p_q) && (span < {3'b000, two_p});
      for (int i = 0; i < CH_NUM; i++) begin
         off[i] = CW'(i) * {1'b0, s_q};
      end
      wrap0 = (c_q[0] == last_cnt);
   end

   // next-state, counter and strobe logic
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      burst_d = burst_q;
      c_d     = c_q;
      pv_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      end_run = 1'b0;
      if (state_q == ST_IDLE) begin
         // one cycle after the request the latched config is checked
         if (start_q) begin
            if (cfg_ok) begin
               state_d = ST_RUN;
               c_d     = off;
               burst_d = '0;
            end else begin
               err_d = 1'b1;
            end
         end else if (io_en && !pwm_dis) begin
            start_d = 1'b1;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            c_d[i] = (c_q[i] == last_cnt) ? '0 : c_q[i] + CW'(1);
         end
         if (wrap0) begin
            pv_d    = 1'b1;
            burst_d = burst_q + 16'd1;
         end
         if (wrap0 && (n_q != 16'd0) && (burst_d == n_q)) end_run = 1'b1;
`ifdef PWM_SOFT_STOP_EN
         if (wrap0 && (state_q == ST_STOP)) end_run = 1'b1;
         else if ((state_q == ST_RUN) && pwm_dis) state_d = ST_STOP;
`else
         if (pwm_dis) end_run = 1'b1;
`endif
         if (end_run) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            for (int i = 0; i < CH_NUM; i++) begin
               c_d[i] = '0;
            end
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   // waveform decode from the current counters; default level when idle
   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (state_q == ST_IDLE) begin
            a_d[i] = io_defaultLevel;
            b_d[i] = io_defaultLevel;
         end else begin
            a_d[i] = (c_q[i] >= d_ext) && (c_q[i] < p_ext);
            b_d[i] = (c_q[i] >= pd_sum) && (c_q[i] < two_p);
         end
      end
   end

   // state, counters and registered outputs
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         burst_q <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            c_q[i] <= '0;
         end
         a_q    <= '0;
         b_q    <= '0;
         pv_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         burst_q <= burst_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pv_q    <= pv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // configuration is captured only when a start request is accepted
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         p_q <= '0;
         d_q <= '0;
         s_q <= '0;
         n_q <= '0;
      end else if (start_d) begin
         p_q <= pulse_period;
         d_q <= die_period;
         s_q <= phase_step;
         n_q <= burst_num;
      end
   end

   assign io_pulseOut_a = a_q;
   assign io_pulseOut_b = b_q;
   assign pulse_valid   = pv_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign cfg_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_die_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pwm_die_multi                                                |
// | Purpose  : Self-checking bench for pwm_die_multi (CH_NUM=2). Honours       |
// |            PWM_SOFT_STOP_EN when the design is built with it.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pwm_die_multi;
   localparam int CH = 2;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst, en, dis, dflt;
   logic [CW-1:0] pp, dp, sp;
   logic [15:0]   nb;
   logic [CH-1:0] oa, ob;
   logic          pv, busy, done, err;

   int total = 0;
   int bad   = 0;

   pwm_die_multi #(.CH_NUM(CH), .CNT_W(CW)) dut (
      .io_clk(clk), .io_rst(rst), .io_en(en), .pwm_dis(dis),
      .pulse_period(pp), .die_period(dp), .phase_step(sp), .burst_num(nb),
      .io_defaultLevel(dflt), .io_pulseOut_a(oa), .io_pulseOut_b(ob),
      .pulse_valid(pv), .busy(busy), .done(done), .cfg_err(err)
   );

   always #5 clk = ~clk;

   // reference model: mode 0 idle, 1 start pending, 2 run, 3 soft stop
   int            m_mode, m_P, m_D, m_S, m_N, m_t;
   logic [CH-1:0] e_a, e_b;
   logic          e_pv, e_done, e_err, e_busy;

   task automatic model_reset();
      m_mode = 0; m_t = 0;
      e_a = '0; e_b = '0;
      e_pv = 0; e_done = 0; e_err = 0; e_busy = 0;
   endtask

   // one clock edge: outputs follow the pre-edge situation, then advance
   task automatic model_step();
      int two_p, pos;
      bit fin;
      two_p = 2 * m_P;
      e_pv = 0; e_done = 0; e_err = 0;
      for (int i = 0; i < CH; i++) begin
         if (m_mode >= 2) begin
            pos    = (i * m_S + m_t) % two_p;
            e_a[i] = (pos >= m_D) && (pos < m_P);
            e_b[i] = (pos >= m_P + m_D);
         end else begin
            e_a[i] = dflt;
            e_b[i] = dflt;
         end
      end
      case (m_mode)
         0: if (en && !dis) begin
               m_P = int'(pp); m_D = int'(dp); m_S = int'(sp); m_N = int'(nb);
               m_mode = 1;
            end
         1: if (m_P > 0 && m_D < m_P && (CH - 1) * m_S < 2 * m_P) begin
               m_mode = 2; m_t = 0;
            end else begin
               e_err = 1; m_mode = 0;
            end
         default: begin
            fin = 0;
            m_t++;
            if (m_t % two_p == 0) begin
               e_pv = 1;
               if (m_N != 0 && m_t / two_p == m_N) fin = 1;
               else if (m_mode == 3) fin = 1;
            end
`ifdef PWM_SOFT_STOP_EN
            if (!fin && m_mode == 2 && dis) m_mode = 3;
`else
            if (dis) fin = 1;
`endif
            if (fin) begin
               e_done = 1; m_mode = 0;
            end
         end
      endcase
      e_busy = (m_mode >= 2);
   endtask

   task automatic check_out(input string nm);
      total++;
      if ({oa, ob, pv, done, err, busy} !== {e_a, e_b, e_pv, e_done, e_err, e_busy}) begin
         bad++;
         $display("FAIL %s @%0t: got a=%b b=%b pv=%b done=%b err=%b busy=%b, want a=%b b=%b pv=%b done=%b err=%b busy=%b",
                  nm, $time, oa, ob, pv, done, err, busy, e_a, e_b, e_pv, e_done, e_err, e_busy);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic tick(input string nm);
      @(posedge clk);
      model_step();
      #1;
      check_out(nm);
   endtask

   typedef struct {
      int p; int d; int s; int n;
      int exp_err; int exp_pv; int exp_busy; int exp_a0;
   } vec_t;
   vec_t vecs [7];

   // start one configuration and gather run statistics
   task automatic run_vec(input int idx);
      int npv, nbusy, nerr, na, guard;
      npv = 0; nbusy = 0; nerr = 0; na = 0; guard = 0;
      pp = vecs[idx].p; dp = vecs[idx].d; sp = vecs[idx].s; nb = 16'(vecs[idx].n);
      dflt = 0; dis = 0; en = 1;
      tick("vec_start");
      en = 0;
      do begin
         tick("vec_run");
         npv += int'(pv); nbusy += int'(busy); nerr += int'(err); na += int'(oa[0]);
         guard++;
      end while ((busy || guard < 3) && guard < 500);
      check_int($sformatf("vec%0d_timeout", idx), int'(guard >= 500), 0);
      check_int($sformatf("vec%0d_cfg_err", idx), nerr, vecs[idx].exp_err);
      check_int($sformatf("vec%0d_pulse_valid", idx), npv, vecs[idx].exp_pv);
      check_int($sformatf("vec%0d_busy_cycles", idx), nbusy, vecs[idx].exp_busy);
      check_int($sformatf("vec%0d_a0_high", idx), na, vecs[idx].exp_a0);
      tick("vec_tail");
   endtask

   initial begin
      int fall, guard, viol, nerr, nbusy, max_m;
      vecs[0] = '{10, 3, 5, 2, 0, 2, 40, 14};  // reference waveform
      vecs[1] = '{ 5, 5, 0, 1, 1, 0,  0,  0};  // D == P
      vecs[2] = '{ 5, 1, 10, 1, 1, 0,  0,  0}; // S == 2P
      vecs[3] = '{ 0, 0, 0, 1, 1, 0,  0,  0};  // P == 0
      vecs[4] = '{ 4, 1, 3, 3, 0, 3, 24,  9};
      vecs[5] = '{ 1, 0, 1, 1, 0, 1,  2,  1};  // minimum period
      vecs[6] = '{ 5, 4, 9, 1, 0, 1, 10,  1};  // largest legal S

      rst = 1; en = 0; dis = 0; dflt = 0;
      pp = '0; dp = '0; sp = '0; nb = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_out("reset_values");
      rst = 0;
      tick("idle_default");

      for (int i = 0; i < 7; i++) run_vec(i);

      // simultaneous start and stop requests in idle: stop wins
      pp = 10; dp = 3; sp = 5; nb = 1; en = 1; dis = 1;
      nerr = 0; nbusy = 0;
      for (int i = 0; i < 4; i++) begin
         tick("en_dis_idle");
         nerr += int'(err); nbusy += int'(busy);
      end
      en = 0; dis = 0;
      check_int("en_dis_no_err", nerr, 0);
      check_int("en_dis_no_busy", nbusy, 0);

      // continuous run stopped by pwm_dis sampled 57 edges after RUN entry
      pp = 10; dp = 3; sp = 5; nb = 0; en = 1;
      tick("dis_start");
      en = 0; fall = -1;
      for (int r = 0; r < 120; r++) begin
         dis = (r == 57);
         tick("dis_run");
         if (!busy && fall < 0) fall = r;
         if (fall >= 0) break;
      end
      dis = 0;
`ifdef PWM_SOFT_STOP_EN
      check_int("dis_busy_fall", fall, 60);
`else
      check_int("dis_busy_fall", fall, 57);
`endif
      repeat (2) tick("dis_tail");

      // long run, never both outputs of a channel high
      pp = 4; dp = 1; sp = 3; nb = 0; en = 1;
      tick("and_start");
      en = 0; viol = 0;
      for (int r = 0; r < 1000; r++) begin
         tick("and_run");
         viol += int'(|(oa & ob));
      end
      check_int("a_and_b_never", viol, 0);
      dis = 1;
      tick("and_stop");
      dis = 0;
      guard = 0;
      while (busy && guard < 20) begin
         tick("and_drain"); guard++;
      end
      check_int("and_drain_timeout", int'(guard >= 20), 0);
      tick("and_tail");

      // asynchronous reset mid-period with default level 1
      dflt = 1; pp = 10; dp = 3; sp = 5; nb = 0; en = 1;
      tick("rst_start");
      en = 0;
      repeat (25) tick("rst_run");
      #2;
      rst = 1;
      model_reset();
      #1;
      check_out("rst_async");
      @(posedge clk);
      #1;
      check_out("rst_held");
      rst = 0;
      tick("rst_release");
      check_int("rst_release_level", int'({oa, ob} == {2 * CH{1'b1}}), 1);
      repeat (3) tick("rst_idle");

      // randomized configurations with random stop and ignored start pulses
      for (int t = 0; t < 40; t++) begin
         int p;
         p  = int'($urandom_range(1, 12));
         pp = p;
         dp = $urandom_range(0, p);
         sp = $urandom_range(0, 2 * p);
         nb = 16'($urandom_range(0, 3));
         dflt = 1'($urandom_range(0, 1));
         dis = 0; en = 1;
         tick("rnd_start");
         en = 0;
         max_m = 0;
         guard = 0;
         while (guard < 300) begin
            dis  = ($urandom_range(0, 29) == 0) || (nb == 0 && guard == 60);
            en   = (m_mode >= 2) && ($urandom_range(0, 7) == 0);
            dflt = (m_mode >= 2) ? 1'($urandom_range(0, 1)) : dflt;
            tick("rnd_run");
            if (m_mode > max_m) max_m = m_mode;
            guard++;
            if (m_mode == 0 && guard > 2) break;
         end
         en = 0; dis = 0;
         check_int("rnd_timeout", int'(guard >= 300), 0);
         tick("rnd_tail");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
